layer_sequencer: RTL and testbench
==================================

Name: layer_sequencer

Overview:
- Time-multiplexed controller for one fully connected layer: out[j] = sum_i(w[j][i]*x[i]) + b[j], for j = 0..OUTPUT_SIZE-1.
- Replaces the parallel bank of weighted-sum units with a single serial MAC.
- Reads weights, inputs and biases from external synchronous RAMs, then writes each neuron result to an output RAM.
- Sits between the network top-level FSM (start/done) and the per-layer memories.

Parameters:
- INPUT_SIZE, 784, inputs per neuron (N), >=1
- OUTPUT_SIZE, 10, neurons in layer (M), >=1
- WIDTH, 16, data width of weights, inputs, biases and outputs
- WADDR_W, $clog2(INPUT_SIZE*OUTPUT_SIZE), weight address width (derived)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin layer; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on layer completion
- mem_rd_en  out  1  read enable shared by weight, input and bias RAMs
- w_addr  out  WADDR_W  weight address = neuron*INPUT_SIZE + idx
- w_data  in  WIDTH  weight RAM data, 1-cycle read latency
- x_addr  out  $clog2(INPUT_SIZE)  input address = idx
- x_data  in  WIDTH  input RAM data, 1-cycle latency
- b_addr  out  $clog2(OUTPUT_SIZE)  bias address = current neuron
- b_data  in  WIDTH  bias RAM data, 1-cycle latency
- out_we  out  1  output RAM write strobe
- out_addr  out  $clog2(OUTPUT_SIZE)  output index
- out_data  out  WIDTH  neuron result

Behaviour:
- Interface: single clock clk; rst is asynchronous and active-high. All outputs are registered.
- Reset values: every output is 0. State = IDLE; neuron, idx and acc are 0.
- FSM states: IDLE, FETCH, MAC, WRITE, DONE.
- IDLE:
  - start=1 -> FETCH with neuron=0.
  - start is ignored in every other state; no queuing.
- FETCH (1 cycle):
  - mem_rd_en=1, idx=0; addresses for element 0 presented; acc cleared to 0.
  - Next state: MAC.
- MAC (exactly N cycles, k = 0..N-1):
  - Cycle k: acc <= acc + (w_data*x_data)[WIDTH-1:0].
  - k=0: also latch b_data into the bias register.
  - k<N-1: mem_rd_en=1 and addresses for element k+1 presented.
  - k=N-1: mem_rd_en=0; next state WRITE.
- WRITE (1 cycle):
  - out_we=1, out_addr=neuron, out_data = acc + bias, mod 2^WIDTH.
  - neuron==M-1 -> DONE; otherwise neuron++ -> FETCH.
- DONE (1 cycle): done=1, busy=1; next state IDLE.
- Arithmetic:
  - Unsigned modulo-2^WIDTH wrap. This is bit-identical to two's-complement for signed data.
  - No saturation, no overflow flag.
- Latency:
  - Start sampled in cycle 0 -> first out_we in cycle N+2.
  - Writes every N+2 cycles; done in cycle M*(N+2)+1.
- Degenerate case N=1: MAC lasts 1 cycle; mem_rd_en is high only in FETCH.
- Address behaviour: addresses hold their last value when mem_rd_en=0. Consumers must qualify reads with mem_rd_en.
- Reset mid-operation: immediate return to IDLE; any in-flight write is dropped (out_we=0); no done pulse.
- Back-to-back layers: start held high through DONE is accepted on the first IDLE cycle (restart 1 cycle after done).

Optional Feature:
- Macro: LAYER_SEQ_ACC_MASK_EN.
- Defined:
  - Extra port mask_in (in, WIDTH), a fresh random mask per neuron.
  - mask_in is sampled in FETCH into mask_reg, and acc is initialised to mask_in instead of 0.
  - WRITE computes out_data = acc - mask_reg + bias, mod 2^WIDTH.
  - The accumulator never holds an unmasked partial sum.
  - Outputs and timing are identical to the unmasked build.
- Undefined: mask_in port and mask_reg are absent; acc clears to 0.

Test Plan:
- N=4, M=3, WIDTH=8; all w=1, x=i+1 (1,2,3,4), b=(0,10,20) -> writes 10, 20, 30 at cycles 6, 12, 18; done at 19.
- Wrap: N=2, M=1, w=(200,100), x=(2,1), b=5 -> out_data = (400+100+5) mod 256 = 249.
- Start asserted while busy (cycle 3) -> ignored; exactly M writes; single done pulse.
- rst asserted in MAC of neuron 1 -> all outputs 0 next edge. Restarting gives results identical to a clean run.
- N=1, M=2, w=(3,4), x=5, b=(1,1) -> outputs 16, 21 at cycles 3 and 6; done at 7.
- LAYER_SEQ_ACC_MASK_EN with random mask_in each FETCH -> out_data sequence matches the unmasked reference run; acc never equals the unmasked partial sum when mask_in != 0.

Source files
------------

// File: rtl/layer_seq_if.sv
// Bus bundle between the layer sequencer and its weight/input/bias/output memories.
// The mask_in signal exists only when LAYER_SEQ_ACC_MASK_EN is defined.
interface layer_seq_if #(
    parameter int INPUT_SIZE  = 784,
    parameter int OUTPUT_SIZE = 10,
    parameter int WIDTH       = 16
);
    localparam int WADDR_W = (INPUT_SIZE * OUTPUT_SIZE > 1) ? $clog2(INPUT_SIZE * OUTPUT_SIZE) : 1;
    localparam int XADDR_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam int BADDR_W = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;

    logic               start;
    logic               busy;
    logic               done;
    logic               mem_rd_en;
    logic [WADDR_W-1:0] w_addr;
    logic [WIDTH-1:0]   w_data;
    logic [XADDR_W-1:0] x_addr;
    logic [WIDTH-1:0]   x_data;
    logic [BADDR_W-1:0] b_addr;
    logic [WIDTH-1:0]   b_data;
    logic               out_we;
    logic [BADDR_W-1:0] out_addr;
    logic [WIDTH-1:0]   out_data;
`ifdef LAYER_SEQ_ACC_MASK_EN
    logic [WIDTH-1:0]   mask_in;
`endif

    modport master (
        input  start, w_data, x_data, b_data,
        output busy, done, mem_rd_en, w_addr, x_addr, b_addr, out_we, out_addr, out_data
`ifdef LAYER_SEQ_ACC_MASK_EN
        , input mask_in
`endif
    );

    modport slave (
        output start, w_data, x_data, b_data,
        input  busy, done, mem_rd_en, w_addr, x_addr, b_addr, out_we, out_addr, out_data
`ifdef LAYER_SEQ_ACC_MASK_EN
        , output mask_in
`endif
    );
endinterface

// File: rtl/layer_sequencer.sv
// Serial-MAC controller for one fully connected layer: out[j] = sum_i w[j][i]*x[i] + b[j].
// Define LAYER_SEQ_ACC_MASK_EN to seed the accumulator with a per-neuron random mask.
module layer_sequencer #(
    parameter int INPUT_SIZE  = 784,
    parameter int OUTPUT_SIZE = 10,
    parameter int WIDTH       = 16
) (
    input  logic        clk,
    input  logic        rst,
    layer_seq_if.master bus_io
);
    localparam int WADDR_W = (INPUT_SIZE * OUTPUT_SIZE > 1) ? $clog2(INPUT_SIZE * OUTPUT_SIZE) : 1;
    localparam int XADDR_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam int BADDR_W = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, MAC, WRITE, DONE} state_t;

    state_t             state_q;
    logic [BADDR_W-1:0] neuron_q;
    logic [XADDR_W-1:0] k_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   bias_q;
    logic               busy_q;
    logic               done_q;
    logic               rd_en_q;
    logic [WADDR_W-1:0] w_addr_q;
    logic [XADDR_W-1:0] x_addr_q;
    logic               out_we_q;
    logic [WIDTH-1:0]   out_data_q;
`ifdef LAYER_SEQ_ACC_MASK_EN
    logic [WIDTH-1:0]   mask_q;
`endif

    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] bias_d;
    logic [WIDTH-1:0] result_d;

    // On the final MAC cycle of N=1 the bias register is loaded on the same edge, so bypass it.
    always_comb begin
        acc_d    = acc_q + bus_io.w_data * bus_io.x_data;
        bias_d   = (k_q == '0) ? bus_io.b_data : bias_q;
`ifdef LAYER_SEQ_ACC_MASK_EN
        result_d = acc_d - mask_q + bias_d;
`else
        result_d = acc_d + bias_d;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            neuron_q   <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            bias_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            w_addr_q   <= '0;
            x_addr_q   <= '0;
            out_we_q   <= 1'b0;
            out_data_q <= '0;
`ifdef LAYER_SEQ_ACC_MASK_EN
            mask_q     <= '0;
`endif
        end else begin
            done_q   <= 1'b0;
            out_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus_io.start) begin
                        state_q  <= FETCH;
                        busy_q   <= 1'b1;
                        rd_en_q  <= 1'b1;
                        neuron_q <= '0;
                        w_addr_q <= '0;
                        x_addr_q <= '0;
                    end
                end
                FETCH: begin
                    state_q <= MAC;
                    k_q     <= '0;
`ifdef LAYER_SEQ_ACC_MASK_EN
                    acc_q   <= bus_io.mask_in;
                    mask_q  <= bus_io.mask_in;
`else
                    acc_q   <= '0;
`endif
                    if (INPUT_SIZE > 1) begin
                        rd_en_q  <= 1'b1;
                        w_addr_q <= w_addr_q + WADDR_W'(1);
                        x_addr_q <= x_addr_q + XADDR_W'(1);
                    end else begin
                        rd_en_q  <= 1'b0;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    if (k_q == '0) bias_q <= bus_io.b_data;
                    if (k_q == XADDR_W'(INPUT_SIZE - 1)) begin
                        state_q    <= WRITE;
                        rd_en_q    <= 1'b0;
                        out_we_q   <= 1'b1;
                        out_data_q <= result_d;
                    end else begin
                        k_q <= k_q + XADDR_W'(1);
                        // Addresses hold once the last element has been requested.
                        if (k_q == XADDR_W'(INPUT_SIZE - 2)) begin
                            rd_en_q  <= 1'b0;
                        end else begin
                            rd_en_q  <= 1'b1;
                            w_addr_q <= w_addr_q + WADDR_W'(1);
                            x_addr_q <= x_addr_q + XADDR_W'(1);
                        end
                    end
                end
                WRITE: begin
                    if (neuron_q == BADDR_W'(OUTPUT_SIZE - 1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q  <= FETCH;
                        neuron_q <= neuron_q + BADDR_W'(1);
                        rd_en_q  <= 1'b1;
                        w_addr_q <= w_addr_q + WADDR_W'(1);
                        x_addr_q <= '0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_io.busy      = busy_q;
    assign bus_io.done      = done_q;
    assign bus_io.mem_rd_en = rd_en_q;
    assign bus_io.w_addr    = w_addr_q;
    assign bus_io.x_addr    = x_addr_q;
    assign bus_io.b_addr    = neuron_q;
    assign bus_io.out_we    = out_we_q;
    assign bus_io.out_addr  = neuron_q;
    assign bus_io.out_data  = out_data_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: three small configurations checked against a cycle-timeline reference model.
module tb_layer_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    int   sel = 0;
    int   total = 0;
    int   bad = 0;

    logic [7:0] wm [0:15];
    logic [7:0] xm [0:3];
    logic [7:0] bm [0:3];
    int         exp_q [0:3];

    always #5 clk = ~clk;

    layer_seq_if #(.INPUT_SIZE(4), .OUTPUT_SIZE(3), .WIDTH(8)) ia();
    layer_seq_if #(.INPUT_SIZE(2), .OUTPUT_SIZE(1), .WIDTH(8)) ib();
    layer_seq_if #(.INPUT_SIZE(1), .OUTPUT_SIZE(2), .WIDTH(8)) ic();

    layer_sequencer #(.INPUT_SIZE(4), .OUTPUT_SIZE(3), .WIDTH(8)) dut_a (.clk(clk), .rst(rst), .bus_io(ia));
    layer_sequencer #(.INPUT_SIZE(2), .OUTPUT_SIZE(1), .WIDTH(8)) dut_b (.clk(clk), .rst(rst), .bus_io(ib));
    layer_sequencer #(.INPUT_SIZE(1), .OUTPUT_SIZE(2), .WIDTH(8)) dut_c (.clk(clk), .rst(rst), .bus_io(ic));

    assign ia.start = start && (sel == 0);
    assign ib.start = start && (sel == 1);
    assign ic.start = start && (sel == 2);

    // Synchronous read RAMs shared by all three instances (only one is active at a time).
    always @(posedge clk) begin
        if (ia.mem_rd_en) begin
            ia.w_data <= wm[ia.w_addr]; ia.x_data <= xm[ia.x_addr]; ia.b_data <= bm[ia.b_addr];
        end
        if (ib.mem_rd_en) begin
            ib.w_data <= wm[ib.w_addr]; ib.x_data <= xm[ib.x_addr]; ib.b_data <= bm[ib.b_addr];
        end
        if (ic.mem_rd_en) begin
            ic.w_data <= wm[ic.w_addr]; ic.x_data <= xm[ic.x_addr]; ic.b_data <= bm[ic.b_addr];
        end
    end

`ifdef LAYER_SEQ_ACC_MASK_EN
    always @(negedge clk) begin
        ia.mask_in = 8'($urandom);
        ib.mask_in = 8'($urandom);
        ic.mask_in = 8'($urandom);
    end
`endif

    logic       m_busy, m_done, m_rd, m_we;
    logic [7:0] m_waddr, m_xaddr, m_baddr, m_oaddr, m_odata;

    always_comb begin
        m_busy = ia.busy; m_done = ia.done; m_rd = ia.mem_rd_en; m_we = ia.out_we;
        m_waddr = 8'(ia.w_addr); m_xaddr = 8'(ia.x_addr); m_baddr = 8'(ia.b_addr);
        m_oaddr = 8'(ia.out_addr); m_odata = ia.out_data;
        if (sel == 1) begin
            m_busy = ib.busy; m_done = ib.done; m_rd = ib.mem_rd_en; m_we = ib.out_we;
            m_waddr = 8'(ib.w_addr); m_xaddr = 8'(ib.x_addr); m_baddr = 8'(ib.b_addr);
            m_oaddr = 8'(ib.out_addr); m_odata = ib.out_data;
        end else if (sel == 2) begin
            m_busy = ic.busy; m_done = ic.done; m_rd = ic.mem_rd_en; m_we = ic.out_we;
            m_waddr = 8'(ic.w_addr); m_xaddr = 8'(ic.x_addr); m_baddr = 8'(ic.b_addr);
            m_oaddr = 8'(ic.out_addr); m_odata = ic.out_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(m_busy), 0);
        chk({tag, "_done"}, 32'(m_done), 0);
        chk({tag, "_rd_en"}, 32'(m_rd), 0);
        chk({tag, "_we"}, 32'(m_we), 0);
        chk({tag, "_waddr"}, 32'(m_waddr), 0);
        chk({tag, "_odata"}, 32'(m_odata), 0);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 16; i++) wm[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 4; i++) begin
            xm[i] = 8'($urandom_range(0, 255));
            bm[i] = 8'($urandom_range(0, 255));
        end
    endtask

    // Reference: out[j] = (b[j] + sum_i w[j*n+i]*x[i]) mod 256.
    task automatic model(input int n, input int m);
        int s;
        for (int j = 0; j < m; j++) begin
            s = int'(bm[j]);
            for (int i = 0; i < n; i++) s += int'(wm[j*n+i]) * int'(xm[i]);
            exp_q[j] = s % 256;
        end
    endtask

    // Cycle c=0 is the cycle in which start is sampled. Each neuron occupies n+2 cycles:
    // offset 0 fetch, 1..n MAC, n+1 write; done follows the last write.
    task automatic run_layer(input int s, input int n, input int m, input int poke_at,
                             input int rst_at, input bit skip_start, input bit hold_out);
        int c_end, o, j;
        sel = s;
        model(n, m);
        c_end = m * (n + 2) + 1;
        if (!skip_start) begin
            @(negedge clk);
            start = 1'b1;
        end
        for (int c = 1; c <= c_end + 1; c++) begin
            @(negedge clk);
            start = (c == poke_at) || (hold_out && c >= c_end);
            o = -1; j = -1;
            if (c < c_end) begin
                o = (c - 1) % (n + 2);
                j = (c - 1) / (n + 2);
            end
            chk("out_we", 32'(m_we), 32'(o == n + 1));
            chk("done", 32'(m_done), 32'(c == c_end));
            chk("busy", 32'(m_busy), 32'(c <= c_end));
            chk("rd_en", 32'(m_rd), 32'(o >= 0 && o < n));
            if (o == n + 1) begin
                chk("out_addr", 32'(m_oaddr), 32'(j));
                chk("out_data", 32'(m_odata), 32'(exp_q[j]));
            end
            if (o >= 0 && o < n) begin
                chk("w_addr", 32'(m_waddr), 32'(j * n + o));
                chk("x_addr", 32'(m_xaddr), 32'(o));
                chk("b_addr", 32'(m_baddr), 32'(j));
            end
            if (c == rst_at) begin
                rst = 1'b1;
                start = 1'b0;
                #1;
                chk_zero("midrst");
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) wm[i] = '0;
        for (int i = 0; i < 4; i++) begin xm[i] = '0; bm[i] = '0; end

        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk_zero("reset");
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // N=4, M=3: all weights 1, x=1..4, b=0,10,20 -> 10, 20, 30
        for (int i = 0; i < 12; i++) wm[i] = 8'd1;
        xm[0] = 8'd1; xm[1] = 8'd2; xm[2] = 8'd3; xm[3] = 8'd4;
        bm[0] = 8'd0; bm[1] = 8'd10; bm[2] = 8'd20;
        run_layer(0, 4, 3, 0, 0, 1'b0, 1'b0);

        // N=2, M=1 wrap: (400+100+5) mod 256 = 249
        wm[0] = 8'd200; wm[1] = 8'd100; xm[0] = 8'd2; xm[1] = 8'd1; bm[0] = 8'd5;
        run_layer(1, 2, 1, 0, 0, 1'b0, 1'b0);

        // N=1, M=2: 3*5+1=16, 4*5+1=21
        wm[0] = 8'd3; wm[1] = 8'd4; xm[0] = 8'd5; bm[0] = 8'd1; bm[1] = 8'd1;
        run_layer(2, 1, 2, 0, 0, 1'b0, 1'b0);

        // start pulsed while busy must be ignored
        fill_rand();
        run_layer(0, 4, 3, 3, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("no_requeue_busy", 32'(m_busy), 0);

        // reset during MAC of neuron 1, then a clean rerun on the same data
        fill_rand();
        run_layer(0, 4, 3, 0, 9, 1'b0, 1'b0);
        run_layer(0, 4, 3, 0, 0, 1'b0, 1'b0);

        // start held through done restarts on the first idle cycle
        fill_rand();
        run_layer(0, 4, 3, 0, 0, 1'b0, 1'b1);
        run_layer(0, 4, 3, 0, 0, 1'b1, 1'b0);

        for (int r = 0; r < 3; r++) begin
            fill_rand();
            run_layer(0, 4, 3, 0, 0, 1'b0, 1'b0);
            fill_rand();
            run_layer(1, 2, 1, 0, 0, 1'b0, 1'b0);
            fill_rand();
            run_layer(2, 1, 2, 0, 0, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
